pos_pio_bank: RTL and testbench

Parametrised Avalon-MM output PIO bank that drives NCH independent WIDTH-bit output channels (sprite/paddle positions, colours) from the Nios II soc into the VGA datapath. Software writes land in shadow registers. They are copied atomically to the outputs either on a frame-sync edge or on an explicit commit, so the display logic never sees a half-updated set of coordinates. The block replaces the per-signal single-register output PIOs, and adds a frame counter and an optional commit interrupt.

---
 rtl/pos_pio_bank.sv | 172 +++++++++++++++++
 tb/tb_pos_pio_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_pio_bank.sv
// pos_pio_bank: Avalon-MM output PIO bank with shadow/active channel registers.
// Shadow writes are copied atomically to out_port on a synchronized frame_sync
// rising edge (auto mode) or on an explicit software commit.
// Optional feature macro: POS_PIO_IRQ_EN adds the commit interrupt
// (irq_stat/irq_en register and irq output); without it irq is tied low.
module pos_pio_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AW-1:0]        address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] out_port,
    output logic                 irq
);

    localparam logic [AW-1:0] A_CTRL = AW'(NCH);
    localparam logic [AW-1:0] A_STAT = AW'(NCH + 1);
    localparam logic [AW-1:0] A_IRQ  = AW'(NCH + 2);

    logic             wr;
    logic [NCH-1:0]   sh_wr;
    logic             sw_commit;
    logic             sync_rise;
    logic             commit;
    logic             unused_wdata;

    logic             fs_meta_q, fs_sync_q, fs_dly_q;
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [WIDTH-1:0] active_q [NCH];
    logic [WIDTH-1:0] active_d [NCH];
    logic             auto_q, auto_d;
    logic             direct_q, direct_d;
    logic             pending_q, pending_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    assign wr           = chipselect && !write_n;
    assign sw_commit    = wr && (address == A_STAT) && writedata[0];
    assign sync_rise    = fs_sync_q && !fs_dly_q;
    assign commit       = pending_q && ((auto_q && sync_rise) || sw_commit);
    assign unused_wdata = ^writedata;

    // Decode which shadow channel (if any) the current write targets.
    always_comb begin
        sh_wr = '0;
        for (int i = 0; i < NCH; i++) begin
            sh_wr[i] = wr && (address == AW'(i));
        end
    end

    // Two-flop synchronizer for frame_sync plus a delay flop for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fs_meta_q <= 1'b0;
            fs_sync_q <= 1'b0;
            fs_dly_q  <= 1'b0;
        end else begin
            fs_meta_q <= frame_sync;
            fs_sync_q <= fs_meta_q;
            fs_dly_q  <= fs_sync_q;
        end
    end

    // Next-state for shadow/active banks, control bits, pending and frame counter.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        auto_d      = auto_q;
        direct_d    = direct_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q + (sync_rise ? 16'd1 : 16'd0);

        // Commit copies the pre-write shadow; a same-cycle write lands afterwards.
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (sh_wr[i]) begin
                shadow_d[i] = writedata[WIDTH-1:0];
                if (direct_q) active_d[i] = writedata[WIDTH-1:0];
            end
        end
        if ((|sh_wr) && !direct_q) pending_d = 1'b1;

        if (wr && (address == A_CTRL)) begin
            auto_d   = writedata[0];
            direct_d = writedata[1];
        end
    end

    // Register bank state; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            auto_q      <= 1'b0;
            direct_q    <= 1'b0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            auto_q      <= auto_d;
            direct_q    <= direct_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_port[g*WIDTH +: WIDTH] = active_q[g];
    end

`ifdef POS_PIO_IRQ_EN
    logic irq_stat_q, irq_stat_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Interrupt status: W1C clear, commit set; set takes priority.
    always_comb begin
        irq_stat_d = irq_stat_q;
        irq_en_d   = irq_en_q;
        if (wr && (address == A_IRQ)) begin
            if (writedata[0]) irq_stat_d = 1'b0;
            irq_en_d = writedata[1];
        end
        if (commit) irq_stat_d = 1'b1;
        irq_d = irq_stat_q && irq_en_q;
    end

    // Interrupt registers; irq output is a registered copy of stat && en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_stat_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Zero-wait-state read mux; unmapped addresses read as 0.
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (address == AW'(i)) readdata = 32'(shadow_q[i]);
        end
        if (address == A_CTRL) readdata = {30'd0, direct_q, auto_q};
        if (address == A_STAT) readdata = {frame_cnt_q, 15'd0, pending_q};
`ifdef POS_PIO_IRQ_EN
        if (address == A_IRQ)  readdata = {30'd0, irq_en_q, irq_stat_q};
`endif
    end

endmodule

// File: tb/tb_pos_pio_bank.sv
// Scoreboard bench for pos_pio_bank: stimulus pushes expected values, a
// negedge monitor pops and compares when a check is presented.
module tb_pos_pio_bank;

    localparam int NCH = 4, WIDTH = 12, AW = 3;
`ifdef POS_PIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [AW-1:0]        address;
    logic                 chipselect;
    logic                 write_n;
    logic [31:0]          writedata;
    logic [31:0]          readdata;
    logic                 frame_sync;
    logic [NCH*WIDTH-1:0] out_port;
    logic                 irq;

    pos_pio_bank #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .frame_sync (frame_sync),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_vld = 1'b0;

    // Monitor: pop the oldest expectation whenever a check is presented.
    always @(negedge clk) begin
        if (chk_vld) begin
            exp_t        e;
            logic [63:0] act;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: check presented, no expected value queued");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = 64'(readdata);
                    1:       act = 64'(out_port);
                    default: act = 64'(irq);
                endcase
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        address    = AW'(a);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic present(input int kind, input logic [63:0] e, input string n);
        sb.push_back('{kind, e, n});
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld    = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string n);
        address    = AW'(a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        present(0, 64'(e), n);
    endtask

    task automatic chk_out(input logic [47:0] e, input string n);
        present(1, 64'(e), n);
    endtask

    task automatic chk_irq(input bit e, input string n);
        present(2, 64'(e), n);
    endtask

    task automatic pulse(input int len);
        frame_sync = 1'b1;
        repeat (len) tick();
        frame_sync = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [47:0] pk(input logic [11:0] c0, input logic [11:0] c1,
                                       input logic [11:0] c2, input logic [11:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        frame_sync = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        for (int a = 0; a < 8; a++) rd(a, 32'h0, "reset_read");
        chk_out(48'h0, "reset_out");
        chk_irq(1'b0, "reset_irq");

        // Shadow write, pending, software commit
        wr(1, 32'h0000_0ABC);
        rd(5, 32'h0000_0001, "pending_set");
        chk_out(48'h0, "no_early_commit");
        wr(5, 32'h1);
        chk_out(pk(12'h0, 12'hABC, 12'h0, 12'h0), "sw_commit_same_edge");
        rd(5, 32'h0, "pending_cleared");
        rd(1, 32'h0000_0ABC, "shadow_read");
        wr(7, 32'hFFFF_FFFF);
        rd(7, 32'h0, "unmapped_read");

        // Auto commit on frame_sync, exactly three edges
        wr(4, 32'h1);
        rd(4, 32'h1, "ctrl_auto_read");
        wr(0, 32'h0000_0123);
        frame_sync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out(pk(12'h0, 12'hABC, 12'h0, 12'h0), "fs_not_before_edge3");
        @(posedge clk);
        #1;
        chk_out(pk(12'h123, 12'hABC, 12'h0, 12'h0), "fs_commit_edge3");
        tick();
        frame_sync = 1'b0;
        repeat (3) tick();
        rd(5, 32'h0001_0000, "frame_cnt_1");
        repeat (5) pulse(2);
        rd(5, 32'h0006_0000, "frame_cnt_6");
        chk_out(pk(12'h123, 12'hABC, 12'h0, 12'h0), "no_commit_without_pending");

        // Shadow write coincident with auto commit
        wr(2, 32'h0000_00AA);
        frame_sync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        address    = AW'(2);
        writedata  = 32'h0000_0055;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        frame_sync = 1'b0;
        chk_out(pk(12'h123, 12'hABC, 12'h0AA, 12'h0), "coinc_active_old");
        rd(2, 32'h0000_0055, "coinc_shadow_new");
        repeat (3) tick();
        rd(5, 32'h0007_0001, "coinc_pending_kept");

        // Interrupt behaviour
        wr(5, 32'h1);
        chk_out(pk(12'h123, 12'hABC, 12'h055, 12'h0), "sw_flush");
        wr(6, 32'h3);
        rd(6, IRQ_ON ? 32'h2 : 32'h0, "irq_en_read");
        chk_irq(1'b0, "irq_idle");
        wr(0, 32'h0000_0200);
        wr(5, 32'h1);
        chk_irq(1'b0, "irq_low_on_commit_edge");
        tick();
        chk_irq(IRQ_ON, "irq_rise_next_edge");
        wr(0, 32'h0000_0201);
        frame_sync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        address    = AW'(6);
        writedata  = 32'h3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        frame_sync = 1'b0;
        chk_out(pk(12'h201, 12'hABC, 12'h055, 12'h0), "coinc2_commit");
        rd(6, IRQ_ON ? 32'h3 : 32'h0, "w1c_loses_to_set");
        tick();
        chk_irq(IRQ_ON, "irq_held");
        wr(6, 32'h3);
        rd(6, IRQ_ON ? 32'h2 : 32'h0, "w1c_cleared");
        tick();
        chk_irq(1'b0, "irq_dropped");
        rd(5, 32'h0008_0000, "frame_cnt_8");

        // Direct mode, width truncation
        wr(4, 32'h2);
        wr(3, 32'h0000_FFFF);
        chk_out(pk(12'h201, 12'hABC, 12'h055, 12'hFFF), "direct_write_edge");
        rd(5, 32'h0008_0000, "direct_no_pending");
        rd(3, 32'h0000_0FFF, "direct_shadow");
        rd(4, 32'h2, "ctrl_direct_read");

        // Asynchronous reset mid-operation
        tick();
        reset_n = 1'b0;
        chk_out(48'h0, "async_reset_out");
        chk_irq(1'b0, "async_reset_irq");
        reset_n = 1'b1;
        tick();
        rd(4, 32'h0, "post_reset_ctrl");
        rd(3, 32'h0, "post_reset_shadow");
        pulse(2);
        rd(5, 32'h0001_0000, "first_rise_after_reset");

        // Clearing auto leaves pending for software to flush
        wr(4, 32'h1);
        wr(0, 32'h0000_0077);
        wr(4, 32'h0);
        pulse(2);
        rd(5, 32'h0002_0001, "auto_off_pending_kept");
        chk_out(48'h0, "auto_off_no_commit");
        wr(5, 32'h1);
        chk_out(pk(12'h077, 12'h0, 12'h0, 12'h0), "auto_off_sw_flush");

        repeat (2) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
